// File: rtl/multichannel_fir_filter_if.sv
// Handshake bundle for multichannel_fir_filter: sample in, result out,
// and the coefficient write port.
interface multichannel_fir_filter_if #(
   parameter int IN_WIDTH    = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int OUT_WIDTH   = 24,
   parameter int N_TAPS      = 8,
   parameter int N_CH        = 4
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int A_W  = $clog2(N_TAPS);

   logic                          in_valid;
   logic                          in_ready;
   logic [CH_W-1:0]               in_ch;
   logic signed [IN_WIDTH-1:0]    in_data;
   logic                          out_valid;
   logic                          out_ready;
   logic [CH_W-1:0]               out_ch;
   logic signed [OUT_WIDTH-1:0]   out_data;
   logic                          out_sat;
   logic                          coeff_we;
   logic [A_W-1:0]                coeff_addr;
   logic signed [COEFF_WIDTH-1:0] coeff_data;
   logic                          coeff_ready;

   modport master (
      output in_valid, in_ch, in_data, out_ready,
      output coeff_we, coeff_addr, coeff_data,
      input  in_ready, out_valid, out_ch, out_data, out_sat,
      input  coeff_ready
   );

   modport slave (
      input  in_valid, in_ch, in_data, out_ready,
      input  coeff_we, coeff_addr, coeff_data,
      output in_ready, out_valid, out_ch, out_data, out_sat,
      output coeff_ready
   );
endinterface

// File: rtl/multichannel_fir_filter.sv
// Time-multiplexed FIR: one shared MAC, per-channel history,
// runtime coefficients, round/shift/saturate on the result.
module multichannel_fir_filter #(
   parameter int IN_WIDTH    = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int N_TAPS      = 8,
   parameter int N_CH        = 4,
   parameter int OUT_WIDTH   = 24,
   parameter int OUT_SHIFT   = 16,
   parameter int ROUND       = 1
) (
   input logic                      clk,
   input logic                      rst,
   multichannel_fir_filter_if.slave bus
);

   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int A_W   = $clog2(N_TAPS);
   localparam int P_W   = IN_WIDTH + COEFF_WIDTH;
   localparam int ACC_W = P_W + A_W;
   localparam int S_W   = ACC_W + 1;
   localparam int C_W   = (S_W > OUT_WIDTH) ? S_W : OUT_WIDTH;
   localparam int R_SH  = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

   localparam logic signed [S_W-1:0] RND =
      (ROUND != 0 && OUT_SHIFT > 0) ? (S_W'(1) << R_SH) : '0;
   localparam logic signed [C_W-1:0] MAX_C =
      {{(C_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [C_W-1:0] MIN_C =
      {{(C_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

   state_t                        state_q, state_d;
   logic [A_W-1:0]                k_q, k_d;
   logic [CH_W-1:0]               ch_q, ch_d;
   logic signed [ACC_W-1:0]       acc_q, acc_d;
   logic signed [COEFF_WIDTH-1:0] coeff_q [N_TAPS];
   logic signed [COEFF_WIDTH-1:0] coeff_d [N_TAPS];
   logic signed [IN_WIDTH-1:0]    hist_q [N_CH][N_TAPS];
   logic signed [IN_WIDTH-1:0]    hist_d [N_CH][N_TAPS];
   logic                          pend_v_q, pend_v_d;
   logic [A_W-1:0]                pend_a_q, pend_a_d;
   logic signed [COEFF_WIDTH-1:0] pend_c_q, pend_c_d;
   logic signed [OUT_WIDTH-1:0]   od_q, od_d;
   logic                          sat_q, sat_d;

   logic                          in_rdy;
   logic                          accept;
   logic                          ch_ok;
   logic                          addr_ok;
   logic signed [P_W-1:0]         prod;
   logic signed [ACC_W-1:0]       sum;
   logic signed [S_W-1:0]         s_w;
   logic signed [C_W-1:0]         s_ext;

   assign in_rdy          = (state_q == IDLE) && !rst;
   assign bus.in_ready    = in_rdy;
   assign bus.coeff_ready = in_rdy;
   assign bus.out_valid   = (state_q == HOLD);
   assign bus.out_ch      = ch_q;
   assign bus.out_data    = od_q;
   assign bus.out_sat     = sat_q;

   // Datapath: current tap product, running sum, scaled result.
   always_comb begin
      prod  = coeff_q[k_q] * hist_q[ch_q][k_q];
      sum   = acc_q + ACC_W'(prod);
      s_w   = (S_W'(sum) + RND) >>> OUT_SHIFT;
      s_ext = C_W'(s_w);
   end

   // Next state. A coefficient write that lands on the same edge as
   // an accepted sample is parked until the result is drained, so the
   // in-flight sample still sees the old coefficient set.
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      ch_d     = ch_q;
      acc_d    = acc_q;
      coeff_d  = coeff_q;
      hist_d   = hist_q;
      pend_v_d = pend_v_q;
      pend_a_d = pend_a_q;
      pend_c_d = pend_c_q;
      od_d     = od_q;
      sat_d    = sat_q;
      accept   = bus.in_valid && in_rdy;
      ch_ok    = 32'(bus.in_ch) < N_CH;
      addr_ok  = 32'(bus.coeff_addr) < N_TAPS;
      unique case (state_q)
         IDLE: begin
            if (accept && ch_ok) begin
               for (int i = N_TAPS - 1; i > 0; i--) begin
                  hist_d[bus.in_ch][i] = hist_q[bus.in_ch][i-1];
               end
               hist_d[bus.in_ch][0] = bus.in_data;
               ch_d    = bus.in_ch;
               acc_d   = '0;
               k_d     = '0;
               state_d = MAC;
            end
            if (bus.coeff_we && in_rdy && addr_ok) begin
               if (accept && ch_ok) begin
                  pend_v_d = 1'b1;
                  pend_a_d = bus.coeff_addr;
                  pend_c_d = bus.coeff_data;
               end else begin
                  coeff_d[bus.coeff_addr] = bus.coeff_data;
               end
            end
         end
         MAC: begin
            acc_d = sum;
            k_d   = k_q + 1'b1;
            if (k_q == A_W'(N_TAPS - 1)) begin
               if (s_ext > MAX_C) begin
                  od_d  = MAX_C[OUT_WIDTH-1:0];
                  sat_d = 1'b1;
               end else if (s_ext < MIN_C) begin
                  od_d  = MIN_C[OUT_WIDTH-1:0];
                  sat_d = 1'b1;
               end else begin
                  od_d  = s_ext[OUT_WIDTH-1:0];
                  sat_d = 1'b0;
               end
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d = IDLE;
               if (pend_v_q) begin
                  coeff_d[pend_a_q] = pend_c_q;
                  pend_v_d          = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset clears history, coefficients and outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         k_q      <= '0;
         ch_q     <= '0;
         acc_q    <= '0;
         coeff_q  <= '{default: '0};
         hist_q   <= '{default: '0};
         pend_v_q <= 1'b0;
         pend_a_q <= '0;
         pend_c_q <= '0;
         od_q     <= '0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         ch_q     <= ch_d;
         acc_q    <= acc_d;
         coeff_q  <= coeff_d;
         hist_q   <= hist_d;
         pend_v_q <= pend_v_d;
         pend_a_q <= pend_a_d;
         pend_c_q <= pend_c_d;
         od_q     <= od_d;
         sat_q    <= sat_d;
      end
   end

endmodule
